// File: rtl/vga_timing_pkg.sv
// -----------------------------------------------------------------------------
// vga_timing_pkg
// Shared definitions for the VGA horizontal and vertical timing stages.
//  - phase_e : line/pixel phase encoding (SYNC/BACK/DISP/FRONT). The encoding
//              is Gray-ordered along the SYNC->BACK->DISP->FRONT sequence, so
//              exactly one state bit flips on every phase change.
//  - 1280x1024@60 default horizontal and vertical phase lengths.
//  - VGA_CW  : default phase counter width, wide enough for every default
//              phase length of both stages.
// No ports (package only).
// -----------------------------------------------------------------------------
package vga_timing_pkg;

  typedef enum logic [1:0] {
    PH_SYNC  = 2'b00,
    PH_BACK  = 2'b01,
    PH_DISP  = 2'b11,
    PH_FRONT = 2'b10
  } phase_e;

  // 1280x1024@60 horizontal timing, in pixel clocks
  localparam int unsigned H_DISP_DEF  = 1280;
  localparam int unsigned H_FRONT_DEF = 48;
  localparam int unsigned H_SYNC_DEF  = 112;
  localparam int unsigned H_BACK_DEF  = 248;

  // 1280x1024@60 vertical timing, in lines (1066 lines per frame)
  localparam int unsigned V_DISP_DEF  = 1024;
  localparam int unsigned V_FRONT_DEF = 1;
  localparam int unsigned V_SYNC_DEF  = 3;
  localparam int unsigned V_BACK_DEF  = 38;

  // Phase counter width; 2**11 = 2048 covers every default phase length
  localparam int unsigned VGA_CW = 11;

endpackage

// File: rtl/vga_phase_cnt.sv
// -----------------------------------------------------------------------------
// vga_phase_cnt
// Generic phase counter shared by the horizontal and vertical timing stages.
// Counts advance pulses within the current phase and flags the final unit of
// that phase. The phase length is supplied by the owner's FSM and may change
// every cycle; the counter only ever compares against it, so it never wraps
// on its own.
// Ports:
//  clk      in   1   clock
//  rst_n    in   1   asynchronous active-low reset (count returns to 0)
//  adv_i    in   1   advance: count one unit this cycle
//  len_i    in   CW  length of the current phase (>=1)
//  cnt_o    out  CW  position within the current phase, 0..len_i-1
//  last_o   out  1   count sits on the final unit of the phase
// -----------------------------------------------------------------------------
module vga_phase_cnt
  import vga_timing_pkg::*;
#(
  parameter int unsigned CW = VGA_CW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          adv_i,
  input  logic [CW-1:0] len_i,
  output logic [CW-1:0] cnt_o,
  output logic          last_o
);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // The final unit is detected by equality, which is why the phase lengths
  // must fit in CW bits: the counter is cleared before it could overflow.
  always_comb begin
    last_o = (cnt_q == (len_i - CW'(1)));
  end

  // Step the count on an advance and clear it when the phase completes so
  // that the next phase starts counting from zero.
  always_comb begin
    cnt_d = cnt_q;
    if (adv_i) begin
      if (last_o) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // Count register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/vga_vtiming.sv
// -----------------------------------------------------------------------------
// vga_vtiming
// Vertical VGA timing generator, fed by the horizontal timing stage. Counts
// line-end pulses through the SYNC -> BACK -> DISP -> FRONT line phases and
// drives vsync, vertical-active, the visible row index and a frame-start
// strobe to the pixel path.
// Optional feature (macro VGA_VTIMING_FRAME_CNT_EN): adds a 16-bit wrapping
// frame counter output that steps together with frame_start.
// Ports:
//  clk          in   1   pixel clock
//  rst_n        in   1   asynchronous active-low reset
//  en           in   1   1 = count line-end pulses, 0 = hold all state
//  h_line_end   in   1   one-cycle pulse on the last pixel clock of a line
//  h_active     in   1   horizontal display-active
//  vsync        out  1   vertical sync, VSYNC_POL while in SYNC
//  v_active     out  1   1 while in DISP
//  pix_active   out  1   h_active & v_active (combinational)
//  line_y       out  CW  visible row in DISP, 0 elsewhere
//  frame_start  out  1   one-cycle strobe on entry to SYNC
//  frame_cnt    out  16  frames started since reset (only with the macro)
// -----------------------------------------------------------------------------
module vga_vtiming
  import vga_timing_pkg::*;
#(
  parameter int unsigned V_DISP    = V_DISP_DEF,
  parameter int unsigned V_FRONT   = V_FRONT_DEF,
  parameter int unsigned V_SYNC    = V_SYNC_DEF,
  parameter int unsigned V_BACK    = V_BACK_DEF,
  parameter bit          VSYNC_POL = 1'b1,
  parameter int unsigned CW        = VGA_CW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          h_line_end,
  input  logic          h_active,
  output logic          vsync,
  output logic          v_active,
  output logic          pix_active,
  output logic [CW-1:0] line_y,
  output logic          frame_start
`ifdef VGA_VTIMING_FRAME_CNT_EN
  ,
  output logic [15:0]   frame_cnt
`endif
);

  localparam int unsigned MAX_LEN_A = (V_DISP > V_FRONT) ? V_DISP : V_FRONT;
  localparam int unsigned MAX_LEN_B = (V_SYNC > V_BACK) ? V_SYNC : V_BACK;
  localparam int unsigned MAX_LEN   = (MAX_LEN_A > MAX_LEN_B) ? MAX_LEN_A : MAX_LEN_B;

  // Every phase must last at least one line and fit in the counter.
  if ((V_DISP < 1) || (V_FRONT < 1) || (V_SYNC < 1) || (V_BACK < 1)) begin : g_len_check
    $error("vga_vtiming: every phase length must be at least 1");
  end
  if ((64'd1 << CW) <= 64'(MAX_LEN)) begin : g_cw_check
    $error("vga_vtiming: CW too narrow for the largest phase length");
  end

  phase_e        state_q;
  phase_e        state_d;
  logic          adv;
  logic [CW-1:0] phase_len;
  logic [CW-1:0] cnt;
  logic          last;

  logic          vsync_q;
  logic          vsync_d;
  logic          v_active_q;
  logic          v_active_d;
  logic [CW-1:0] line_y_q;
  logic [CW-1:0] line_y_d;
  logic          frame_start_q;
  logic          frame_start_d;

  // Line-end pulses arriving while disabled are simply dropped.
  assign adv = en & h_line_end;

  // Length of the phase currently being counted
  always_comb begin
    phase_len = CW'(V_SYNC);
    unique case (state_q)
      PH_SYNC:  phase_len = CW'(V_SYNC);
      PH_BACK:  phase_len = CW'(V_BACK);
      PH_DISP:  phase_len = CW'(V_DISP);
      PH_FRONT: phase_len = CW'(V_FRONT);
      default:  phase_len = CW'(V_SYNC);
    endcase
  end

  vga_phase_cnt #(
    .CW(CW)
  ) u_line_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .adv_i (adv),
    .len_i (phase_len),
    .cnt_o (cnt),
    .last_o(last)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= PH_SYNC;
    end else begin
      state_q <= state_d;
    end
  end

  // Next phase: move on only when the final line of the current phase ends.
  always_comb begin
    state_d = state_q;
    if (adv && last) begin
      unique case (state_q)
        PH_SYNC:  state_d = PH_BACK;
        PH_BACK:  state_d = PH_DISP;
        PH_DISP:  state_d = PH_FRONT;
        PH_FRONT: state_d = PH_SYNC;
        default:  state_d = PH_SYNC;
      endcase
    end
  end

  // Output decode from the next phase, so the registered outputs describe
  // the line that begins at the advancing edge. The row index follows the
  // counter's next value: it restarts at 0 on entry to DISP and is forced
  // to 0 outside DISP.
  always_comb begin
    vsync_d       = (state_d == PH_SYNC) ? VSYNC_POL : ~VSYNC_POL;
    v_active_d    = (state_d == PH_DISP);
    line_y_d      = line_y_q;
    frame_start_d = adv & last & (state_q == PH_FRONT);
    if (adv) begin
      if ((state_d == PH_DISP) && !last) begin
        line_y_d = cnt + CW'(1);
      end else begin
        line_y_d = '0;
      end
    end
  end

  // Output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_q       <= VSYNC_POL;
      v_active_q    <= 1'b0;
      line_y_q      <= '0;
      frame_start_q <= 1'b0;
    end else begin
      vsync_q       <= vsync_d;
      v_active_q    <= v_active_d;
      line_y_q      <= line_y_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign vsync       = vsync_q;
  assign v_active    = v_active_q;
  assign line_y      = line_y_q;
  assign frame_start = frame_start_q;
  assign pix_active  = h_active & v_active_q;

`ifdef VGA_VTIMING_FRAME_CNT_EN
  logic [15:0] frame_cnt_q;

  // Frame counter steps on the same edge that raises frame_start, so both
  // become visible together; it wraps freely at 16 bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt_q <= 16'd0;
    end else if (frame_start_d) begin
      frame_cnt_q <= frame_cnt_q + 16'd1;
    end
  end

  assign frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_vga_vtiming.sv
// -----------------------------------------------------------------------------
// tb_vga_vtiming
// Self-checking bench for vga_vtiming with a 10-line frame (SYNC 2, BACK 3,
// DISP 4, FRONT 1). Two instances share the stimulus: one with active-high
// vsync and one with active-low vsync. The reference model tracks the line
// number within the frame and derives every output from it arithmetically.
// -----------------------------------------------------------------------------
module tb_vga_vtiming;

  localparam int V_DISP  = 4;
  localparam int V_FRONT = 1;
  localparam int V_SYNC  = 2;
  localparam int V_BACK  = 3;
  localparam int CW      = 4;
  localparam int TOTAL   = V_DISP + V_FRONT + V_SYNC + V_BACK;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en;
  logic          h_line_end;
  logic          h_active;

  logic          vsync_a;
  logic          v_active_a;
  logic          pix_a;
  logic [CW-1:0] line_y_a;
  logic          fs_a;
  logic          vsync_b;
  logic          v_active_b;
  logic          pix_b;
  logic [CW-1:0] line_y_b;
  logic          fs_b;
`ifdef VGA_VTIMING_FRAME_CNT_EN
  logic [15:0]   fcnt_a;
  logic [15:0]   fcnt_b;
`endif

  typedef struct {
    bit vsync;
    bit v_active;
    int line_y;
    bit frame_start;
    int frame_cnt;
  } exp_t;

  exp_t expQ[$];
  exp_t cur;
  int   lineNo;
  int   frameCnt;
  int   checks   = 0;
  int   failures = 0;
  logic advSeen;

  vga_vtiming #(
    .V_DISP(V_DISP), .V_FRONT(V_FRONT), .V_SYNC(V_SYNC), .V_BACK(V_BACK),
    .VSYNC_POL(1'b1), .CW(CW)
  ) u_dut_a (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .h_line_end (h_line_end),
    .h_active   (h_active),
    .vsync      (vsync_a),
    .v_active   (v_active_a),
    .pix_active (pix_a),
    .line_y     (line_y_a),
    .frame_start(fs_a)
`ifdef VGA_VTIMING_FRAME_CNT_EN
    ,
    .frame_cnt  (fcnt_a)
`endif
  );

  vga_vtiming #(
    .V_DISP(V_DISP), .V_FRONT(V_FRONT), .V_SYNC(V_SYNC), .V_BACK(V_BACK),
    .VSYNC_POL(1'b0), .CW(CW)
  ) u_dut_b (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .h_line_end (h_line_end),
    .h_active   (h_active),
    .vsync      (vsync_b),
    .v_active   (v_active_b),
    .pix_active (pix_b),
    .line_y     (line_y_b),
    .frame_start(fs_b)
`ifdef VGA_VTIMING_FRAME_CNT_EN
    ,
    .frame_cnt  (fcnt_b)
`endif
  );

  // Free-running pixel clock
  always #5 clk = ~clk;

  // Expected outputs while sitting on line l of the frame (line 0 = first
  // SYNC line); fs says whether this line was just entered from FRONT.
  function automatic exp_t modelAt(int l, bit fs, int fc);
    exp_t e;
    e.vsync       = (l < V_SYNC);
    e.v_active    = (l >= V_SYNC + V_BACK) && (l < V_SYNC + V_BACK + V_DISP);
    e.line_y      = e.v_active ? (l - (V_SYNC + V_BACK)) : 0;
    e.frame_start = fs;
    e.frame_cnt   = fc;
    return e;
  endfunction

  task automatic checkOutput(string name, logic [31:0] actual, logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic compareAll(exp_t e);
    checkOutput("vsync_pos",      32'(vsync_a),    32'(e.vsync));
    checkOutput("vsync_neg",      32'(vsync_b),    32'(!e.vsync));
    checkOutput("v_active_pos",   32'(v_active_a), 32'(e.v_active));
    checkOutput("v_active_neg",   32'(v_active_b), 32'(e.v_active));
    checkOutput("line_y_pos",     32'(line_y_a),   32'(e.line_y));
    checkOutput("line_y_neg",     32'(line_y_b),   32'(e.line_y));
    checkOutput("frame_start_pos", 32'(fs_a),      32'(e.frame_start));
    checkOutput("frame_start_neg", 32'(fs_b),      32'(e.frame_start));
    checkOutput("pix_active_pos", 32'(pix_a),      32'(h_active & e.v_active));
    checkOutput("pix_active_neg", 32'(pix_b),      32'(h_active & e.v_active));
`ifdef VGA_VTIMING_FRAME_CNT_EN
    checkOutput("frame_cnt_pos",  32'(fcnt_a),     32'(e.frame_cnt));
    checkOutput("frame_cnt_neg",  32'(fcnt_b),     32'(e.frame_cnt));
`endif
  endtask

  // Remember whether the DUT saw a counted line end at each rising edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      advSeen <= 1'b0;
    end else begin
      advSeen <= en & h_line_end;
    end
  end

  // Monitor: after a counted line end, pop the next expectation from the
  // scoreboard; otherwise the outputs must hold with frame_start low.
  always @(negedge clk) begin
    #2;
    if (rst_n) begin
      if (advSeen) begin
        if (expQ.size() == 0) begin
          checkOutput("scoreboard_underflow", 32'd1, 32'd0);
        end else begin
          cur = expQ.pop_front();
          compareAll(cur);
          cur.frame_start = 1'b0;
        end
      end else begin
        compareAll(cur);
      end
    end
  end

  // Drive one clock of stimulus; a counted pulse advances the model.
  task automatic applyStimulus(bit pulse, bit enable);
    @(negedge clk);
    en         = enable;
    h_line_end = pulse;
    h_active   = 1'($urandom);
    if (pulse && enable) begin
      lineNo = (lineNo + 1) % TOTAL;
      if (lineNo == 0) begin
        frameCnt = (frameCnt + 1) & 16'hFFFF;
      end
      expQ.push_back(modelAt(lineNo, lineNo == 0, frameCnt));
    end
  endtask

  // Pulse reset mid-cycle and check that it takes effect immediately.
  task automatic doReset();
    @(negedge clk);
    en         = 1'b0;
    h_line_end = 1'b0;
    #4;
    rst_n = 1'b0;
    #1;
    expQ.delete();
    lineNo   = 0;
    frameCnt = 0;
    cur      = modelAt(0, 1'b0, 0);
    compareAll(cur);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Stimulus sequence
  initial begin
    rst_n      = 1'b1;
    en         = 1'b0;
    h_line_end = 1'b0;
    h_active   = 1'b0;
    lineNo     = 0;
    frameCnt   = 0;
    cur        = modelAt(0, 1'b0, 0);
    #1;
    rst_n = 1'b0;

    doReset();

    // One frame of pulses spaced 8 clocks apart
    for (int i = 0; i < TOTAL; i++) begin
      applyStimulus(1'b1, 1'b1);
      repeat (7) applyStimulus(1'b0, 1'b1);
    end

    // Pulses while disabled are dropped
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 1'b0);
      repeat (2) applyStimulus(1'b0, 1'b0);
    end

    // Back-to-back pulses: a whole frame in TOTAL cycles
    for (int i = 0; i < TOTAL; i++) applyStimulus(1'b1, 1'b1);
    repeat (3) applyStimulus(1'b0, 1'b1);

    // Randomized enables and pulse density
    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(0, 2) == 0, $urandom_range(0, 3) != 0);
    end

    // Reset while in DISP with line_y = 2, then resume counting
    doReset();
    for (int i = 0; i < V_SYNC + V_BACK + 2; i++) applyStimulus(1'b1, 1'b1);
    applyStimulus(1'b0, 1'b1);
    doReset();
    applyStimulus(1'b1, 1'b1);
    repeat (2) applyStimulus(1'b0, 1'b1);

    // Several full frames to exercise frame counting
    for (int i = 0; i < 3 * TOTAL; i++) begin
      applyStimulus(1'b1, 1'b1);
      applyStimulus(1'b0, 1'b1);
    end
    repeat (3) applyStimulus(1'b0, 1'b1);

    checkOutput("scoreboard_empty", 32'(expQ.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Safety net so the run always terminates
  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
